// File: rtl/reg_decoder_pkg.sv
// reg_decoder_pkg: shared states and protocol constants for the register command decoder
package reg_decoder_pkg;
    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        RESP
    } state_t;

    localparam logic [5:0] CMD_SYNC = 6'b010100;
    localparam logic [7:0] RESP_OK  = 8'hA5;
    localparam logic [7:0] RESP_ERR = 8'hEE;
endpackage

// File: rtl/registers_manager_if.sv
// RegistersManagerInterface: single-transaction register bus between decoder and register manager
interface RegistersManagerInterface #(
    parameter int DATA_LENGTH = 32,
    parameter int ADDRWIDTH   = 8
);
    logic [ADDRWIDTH-1:0]   address;
    logic [DATA_LENGTH-1:0] writeData;
    logic [DATA_LENGTH-1:0] readData;
    logic                   writeEnable;
    logic                   readEnable;
    logic                   writeAdmin;
    logic                   writeAck;

    modport internal (
        output address, writeData, writeEnable, readEnable, writeAdmin,
        input  readData, writeAck
    );

    modport external (
        input  address, writeData, writeEnable, readEnable, writeAdmin,
        output readData, writeAck
    );
endinterface

// File: rtl/reg_decoder_tx_serializer.sv
// reg_decoder_tx_serializer: parallel load of up to NBYTES bytes, MSB-first valid/ready byte output
module reg_decoder_tx_serializer #(
    parameter int NBYTES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [NBYTES*8-1:0]           load_data,
    input  logic [$clog2(NBYTES+1)-1:0]   load_len,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          done
);
    localparam int W  = NBYTES * 8;
    localparam int LW = $clog2(NBYTES + 1);

    logic [W-1:0]  shift_q, shift_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          fire;

    assign tx_valid = cnt_q != '0;
    assign tx_data  = shift_q[W-1 -: 8];
    assign fire     = tx_valid && tx_ready;
    assign done     = fire && cnt_q == LW'(1);

    always_comb begin
        shift_d = load ? load_data : fire ? shift_q << 8 : shift_q;
        cnt_d   = load ? load_len : fire ? cnt_q - LW'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/register_command_decoder.sv
// register_command_decoder: byte-stream command parser driving single register read/write transactions.
// Optional write-ack timeout enabled by defining REG_DECODER_ACK_TIMEOUT_EN.
module register_command_decoder
    import reg_decoder_pkg::*;
#(
    parameter int DATA_LENGTH = 32,
    parameter int ADDRWIDTH   = 8
`ifdef REG_DECODER_ACK_TIMEOUT_EN
    , parameter int ACK_TIMEOUT = 16
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 rxData,
    input  logic                       rxValid,
    output logic                       rxReady,
    output logic [7:0]                 txData,
    output logic                       txValid,
    input  logic                       txReady,
    RegistersManagerInterface.internal regBus,
    output logic                       busy
);
    localparam int NBYTES = DATA_LENGTH / 8;
    localparam int BW     = NBYTES > 1 ? $clog2(NBYTES) : 1;
    localparam int LW     = $clog2(NBYTES + 1);

    state_t                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   address_q, address_d;
    logic [DATA_LENGTH-1:0] write_data_q, write_data_d;
    logic                   write_en_q, write_en_d;
    logic                   read_en_q, read_en_d;
    logic                   admin_q, admin_d;
    logic                   is_wr_q, is_wr_d;
    logic [BW-1:0]          byte_cnt_q, byte_cnt_d;
    logic                   rx_fire;
    logic                   ld;
    logic [DATA_LENGTH-1:0] ld_data;
    logic [LW-1:0]          ld_len;
    logic                   tx_done;
`ifdef REG_DECODER_ACK_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0]          ack_cnt_q, ack_cnt_d;
`endif

    assign rxReady            = state_q inside {IDLE, GET_ADDR, GET_DATA};
    assign busy               = state_q != IDLE;
    assign rx_fire            = rxValid && rxReady;
    assign regBus.address     = address_q;
    assign regBus.writeData   = write_data_q;
    assign regBus.writeEnable = write_en_q;
    assign regBus.readEnable  = read_en_q;
    assign regBus.writeAdmin  = admin_q;

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        write_en_d   = write_en_q;
        read_en_d    = 1'b0;
        admin_d      = admin_q;
        is_wr_d      = is_wr_q;
        byte_cnt_d   = byte_cnt_q;
        ld           = 1'b0;
        ld_data      = '0;
        ld_len       = '0;
`ifdef REG_DECODER_ACK_TIMEOUT_EN
        ack_cnt_d    = '0;
`endif
        case (state_q)
            IDLE: if (rx_fire) begin
                if (rxData[7:2] == CMD_SYNC) begin
                    state_d = GET_ADDR;
                    admin_d = rxData[1];
                    is_wr_d = rxData[0];
                end else begin
                    ld      = 1'b1;
                    ld_data = DATA_LENGTH'(RESP_ERR) << (DATA_LENGTH - 8);
                    ld_len  = LW'(1);
                    state_d = RESP;
                end
            end
            GET_ADDR: if (rx_fire) begin
                address_d  = rxData[ADDRWIDTH-1:0];
                byte_cnt_d = '0;
                state_d    = is_wr_q ? GET_DATA : RD_ISSUE;
                read_en_d  = !is_wr_q;
            end
            GET_DATA: if (rx_fire) begin
                write_data_d = (write_data_q << 8) | DATA_LENGTH'(rxData);
                if (byte_cnt_q == BW'(NBYTES - 1)) begin
                    byte_cnt_d = '0;
                    write_en_d = 1'b1;
                    state_d    = WR_ISSUE;
                end else begin
                    byte_cnt_d = byte_cnt_q + BW'(1);
                end
            end
            WR_ISSUE: if (regBus.writeAck) begin
                write_en_d = 1'b0;
                ld         = 1'b1;
                ld_data    = DATA_LENGTH'(RESP_OK) << (DATA_LENGTH - 8);
                ld_len     = LW'(1);
                state_d    = RESP;
            end
`ifdef REG_DECODER_ACK_TIMEOUT_EN
            else if (ack_cnt_q == TW'(ACK_TIMEOUT - 1)) begin
                write_en_d = 1'b0;
                ld         = 1'b1;
                ld_data    = DATA_LENGTH'(RESP_ERR) << (DATA_LENGTH - 8);
                ld_len     = LW'(1);
                state_d    = RESP;
            end else begin
                ack_cnt_d  = ack_cnt_q + TW'(1);
            end
`endif
            RD_ISSUE: state_d = RD_WAIT;
            // readData is valid exactly one cycle after the readEnable pulse
            RD_WAIT: begin
                ld      = 1'b1;
                ld_data = regBus.readData;
                ld_len  = LW'(NBYTES);
                state_d = RESP;
            end
            RESP: if (tx_done) begin
                admin_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            address_q    <= '0;
            write_data_q <= '0;
            write_en_q   <= 1'b0;
            read_en_q    <= 1'b0;
            admin_q      <= 1'b0;
            is_wr_q      <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            write_en_q   <= write_en_d;
            read_en_q    <= read_en_d;
            admin_q      <= admin_d;
            is_wr_q      <= is_wr_d;
            byte_cnt_q   <= byte_cnt_d;
        end
    end

`ifdef REG_DECODER_ACK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) ack_cnt_q <= '0;
        else       ack_cnt_q <= ack_cnt_d;
    end
`endif

    reg_decoder_tx_serializer #(.NBYTES(NBYTES)) u_tx (
        .clk       (clk),
        .rst       (reset),
        .load      (ld),
        .load_data (ld_data),
        .load_len  (ld_len),
        .tx_data   (txData),
        .tx_valid  (txValid),
        .tx_ready  (txReady),
        .done      (tx_done)
    );
endmodule

// File: tb/tb_register_command_decoder.sv
// tb_register_command_decoder: scoreboard bench; expected tx bytes and bus transactions are queued by stimulus
module tb_register_command_decoder;
    typedef struct {
        logic        wr;
        logic        adm;
        logic [7:0]  addr;
        logic [31:0] data;
        int          len;
    } bus_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rxData = 8'h00;
    logic       rxValid = 1'b0;
    logic       rxReady;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady = 1'b1;
    logic       busy;

    logic        ack_en = 1'b1;
    logic        stray_ack = 1'b0;
    int          ack_delay = 0;
    int          we_cnt = 0;
    logic [31:0] rd_val = 32'h0;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_tx[$];
    bus_t       exp_bus[$];

    RegistersManagerInterface #(.DATA_LENGTH(32), .ADDRWIDTH(8)) bus ();

    register_command_decoder #(.DATA_LENGTH(32), .ADDRWIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .rxData  (rxData),
        .rxValid (rxValid),
        .rxReady (rxReady),
        .txData  (txData),
        .txValid (txValid),
        .txReady (txReady),
        .regBus  (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // register manager model: ack after ack_delay cycles of writeEnable, read data one cycle after readEnable
    always @(posedge clk) begin
        we_cnt        <= bus.writeEnable ? we_cnt + 1 : 0;
        bus.readData  <= bus.readEnable ? rd_val : 32'hBAD0BAD0;
    end
    assign bus.writeAck = stray_ack || (ack_en && bus.writeEnable && we_cnt == ack_delay);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clk) begin
        if (!reset && txValid && txReady) begin
            if (exp_tx.size() == 0) fail("tx_extra_byte");
            else chk("tx_byte", txData, exp_tx.pop_front());
        end
    end

    bus_t e;
    logic re_prev = 1'b0, we_prev = 1'b0;
    int   we_run = 0, we_len_exp = 0;
    always @(negedge clk) begin
        if (reset) begin
            re_prev = 1'b0;
            we_prev = 1'b0;
            we_run  = 0;
        end else begin
            if (bus.readEnable) begin
                if (re_prev) fail("re_pulse_width");
                else if (exp_bus.size() == 0) fail("bus_extra_read");
                else begin
                    e = exp_bus.pop_front();
                    chk("bus_kind_rd", 32'd0, 32'(e.wr));
                    chk("rd_addr", bus.address, e.addr);
                    chk("rd_admin", bus.writeAdmin, e.adm);
                end
            end
            if (bus.writeEnable && !we_prev) begin
                we_run = 0;
                if (exp_bus.size() == 0) fail("bus_extra_write");
                else begin
                    e = exp_bus.pop_front();
                    chk("bus_kind_wr", 32'd1, 32'(e.wr));
                    chk("wr_addr", bus.address, e.addr);
                    chk("wr_data", bus.writeData, e.data);
                    chk("wr_admin", bus.writeAdmin, e.adm);
                    we_len_exp = e.len;
                end
            end
            if (bus.writeEnable) we_run++;
            if (!bus.writeEnable && we_prev) chk("we_len", we_run, we_len_exp);
            re_prev = bus.readEnable;
            we_prev = bus.writeEnable;
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rxData  = b;
        rxValid = 1'b1;
        while (!rxReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail("rx_accept_timeout");
        @(posedge clk);
        #1 rxValid = 1'b0;
    endtask

    task automatic send_all(input logic [7:0] b[$]);
        foreach (b[i]) send(b[i]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_tx.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail("idle_timeout");
    endtask

    task automatic chk_rst();
        chk("rst_rxReady", rxReady, 1);
        chk("rst_txValid", txValid, 0);
        chk("rst_txData", txData, 0);
        chk("rst_busy", busy, 0);
        chk("rst_address", bus.address, 0);
        chk("rst_writeData", bus.writeData, 0);
        chk("rst_writeEnable", bus.writeEnable, 0);
        chk("rst_readEnable", bus.readEnable, 0);
        chk("rst_writeAdmin", bus.writeAdmin, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst();
        reset = 1'b0;

        // plain write, ack three cycles after writeEnable rises
        ack_delay = 3;
        exp_bus.push_back('{1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 4});
        exp_tx.push_back(8'hA5);
        send_all('{8'h51, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
        chk("wr_latency", bus.writeEnable, 1);
        wait_idle();

        // admin read with latency checks
        rd_val = 32'h12345678;
        exp_bus.push_back('{1'b0, 1'b1, 8'h04, 32'h0, 0});
        exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
        send_all('{8'h52, 8'h04});
        chk("rd_latency_re", bus.readEnable, 1);
        @(posedge clk); #1;
        chk("rd_re_drop", bus.readEnable, 0);
        chk("rd_txvalid_early", txValid, 0);
        @(posedge clk); #1;
        chk("rd_txvalid_first", txValid, 1);
        wait_idle();
        chk("admin_cleared", bus.writeAdmin, 0);

        // invalid command, then a normal read
        exp_tx.push_back(8'hEE);
        send(8'hFF);
        wait_idle();
        rd_val = 32'hCAFEF00D;
        exp_bus.push_back('{1'b0, 1'b0, 8'h33, 32'h0, 0});
        exp_tx.push_back(8'hCA); exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'hF0); exp_tx.push_back(8'h0D);
        send_all('{8'h50, 8'h33});
        wait_idle();

        // response stalled by txReady low for five cycles
        txReady = 1'b0;
        rd_val = 32'h0102A0FF;
        exp_bus.push_back('{1'b0, 1'b0, 8'h7E, 32'h0, 0});
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h02);
        exp_tx.push_back(8'hA0); exp_tx.push_back(8'hFF);
        send_all('{8'h50, 8'h7E});
        n = 0;
        while (!txValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail("stall_txvalid_timeout");
        repeat (5) begin
            @(negedge clk);
            chk("stall_txValid", txValid, 1);
            chk("stall_txData", txData, 8'h01);
            chk("stall_rxReady", rxReady, 0);
        end
        txReady = 1'b1;
        wait_idle();

        // stray ack while idle must do nothing
        @(negedge clk); stray_ack = 1'b1;
        @(negedge clk); stray_ack = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_txValid", txValid, 0);

        // reset after the second data byte of an admin write
        send_all('{8'h53, 8'h20, 8'h11, 8'h22});
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk_rst();
        reset = 1'b0;
        ack_delay = 0;
        exp_bus.push_back('{1'b1, 1'b1, 8'h3C, 32'h01234567, 1});
        exp_tx.push_back(8'hA5);
        send_all('{8'h53, 8'h3C, 8'h01, 8'h23, 8'h45, 8'h67});
        wait_idle();

`ifdef REG_DECODER_ACK_TIMEOUT_EN
        ack_en = 1'b0;
        exp_bus.push_back('{1'b1, 1'b0, 8'h05, 32'hAABBCCDD, 16});
        exp_tx.push_back(8'hEE);
        send_all('{8'h51, 8'h05, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
        wait_idle();
        ack_en = 1'b1;
        chk("timeout_idle", busy, 0);
`endif

        repeat (3) @(negedge clk);
        chk("tx_left", exp_tx.size(), 0);
        chk("bus_left", exp_bus.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/register_command_decoder.md
Name: register_command_decoder

Overview:
Upstream master of the register manager bus. It parses a byte-stream command protocol from the serial link (UART/SPI byte layer) and issues single register read/write transactions on a RegistersManagerInterface. It returns write status or read data as a byte stream. It is the only driver of the internal modport in the DAQ digital top.

Parameters:
DATA_LENGTH, 32, register data width; must be a multiple of 8; NBYTES = DATA_LENGTH/8
ADDRWIDTH, 8, register address width; must be ≤ 8 (one address byte)
ACK_TIMEOUT, 16, cycles to wait for writeAck before reporting an error (optional feature only)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
rxData  input  8  incoming command byte
rxValid  input  1  rxData valid; byte accepted when rxValid && rxReady
rxReady  output  1  decoder can accept a byte
txData  output  8  response byte
txValid  output  1  txData valid; held until txReady
txReady  input  1  downstream accepts response byte
regBus  modport internal  -  RegistersManagerInterface (DATA_LENGTH, ADDRWIDTH): drives address, writeData, writeEnable, readEnable, writeAdmin; samples readData, writeAck
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; rxReady=1; txValid=0; txData=0; address=0; writeData=0; writeEnable=0; readEnable=0; writeAdmin=0; busy=0; byte counter=0.
- Command byte: bits[7:2] must equal 6'b010100. bit1 = admin, copied to writeAdmin. bit0: 1=write, 0=read.
- States:
  - IDLE: accept a byte. Valid command -> GET_ADDR. Invalid command -> RESP with error byte 0xEE.
  - GET_ADDR: accept a byte; address = byte[ADDRWIDTH-1:0]. Write -> GET_DATA. Read -> RD_ISSUE.
  - GET_DATA: accept NBYTES bytes, MSB first, shifted into writeData. Counter wraps 0..NBYTES-1. After the last byte -> WR_ISSUE.
  - WR_ISSUE: writeEnable=1 held every cycle until writeAck is sampled high. On that cycle: writeEnable drops the next cycle; response byte 0xA5 -> RESP.
  - RD_ISSUE: readEnable=1 for exactly one cycle -> RD_WAIT.
  - RD_WAIT: readData captured in the cycle after readEnable (fixed latency 1). Load NBYTES response bytes, MSB first -> RESP.
  - RESP: txValid=1 with the current byte; advance on txValid && txReady. After the last byte, txValid=0 -> IDLE.
- rxReady=1 only in IDLE, GET_ADDR, GET_DATA. Bytes offered in other states are not accepted (upstream stalls).
- rxValid together with txReady in the same cycle is impossible to conflict: rx and tx are never active in the same state.
- writeAdmin and address stay stable from GET_ADDR until the transaction ends. writeAdmin clears on return to IDLE.
- A writeAck seen outside WR_ISSUE is ignored.
- Reset asserted mid-transaction: next edge forces the reset values. Any partial command or pending response is discarded; writeEnable/readEnable drop within one cycle.
- Total latency, write: last data byte accepted -> writeEnable high on the next cycle.
- Total latency, read: address byte accepted -> readEnable high next cycle -> first txValid 2 cycles after readEnable.

Optional Feature:
Macro REG_DECODER_ACK_TIMEOUT_EN.
- Defined: a counter runs in WR_ISSUE. If writeAck has not been seen after ACK_TIMEOUT cycles, drop writeEnable and respond 0xEE.
- Undefined: WR_ISSUE waits indefinitely for writeAck; no counter is synthesized.

Decomposition:
- Package reg_decoder_pkg holds:
  - state enum typedef
  - CMD_SYNC = 6'b010100
  - RESP_OK = 8'hA5
  - RESP_ERR = 8'hEE
- One natural sub-module, reg_decoder_tx_serializer: parallel load of up to NBYTES bytes, MSB-first output with valid/ready. It is reused for both the single-byte status response and the read-data response.

Test Plan:
- Write: bytes 0x51, 0x10, 0xDE, 0xAD, 0xBE, 0xEF; writeAck returned 3 cycles after writeEnable rises -> address=0x10, writeData=0xDEADBEEF, writeAdmin=0, writeEnable high exactly until the ack cycle; tx 0xA5.
- Admin read: bytes 0x52, 0x04; manager returns readData=0x12345678 one cycle after readEnable -> readEnable is a 1-cycle pulse, writeAdmin=1; tx 0x12, 0x34, 0x56, 0x78 in order.
- Invalid command byte 0xFF -> no regBus activity; tx 0xEE; then a valid read completes normally.
- txReady held low 5 cycles during a read response -> txValid and txData stay stable; no byte lost or duplicated; rxReady=0 throughout.
- Reset pulsed after the 2nd data byte of a write -> all outputs at reset values next cycle; a subsequent full write succeeds with correct data.
- With REG_DECODER_ACK_TIMEOUT_EN and ACK_TIMEOUT=16: write with writeAck never asserted -> writeEnable drops after 16 cycles; tx 0xEE; decoder returns to IDLE.
